// File: rtl/rv_multicycle_ctrl_if.sv
// Control bundle between the multi-cycle sequencer and the RV32 datapath /
// memory port. The master side is the sequencer: it consumes the decoded
// opcode, the branch comparator result and the memory handshake, and
// drives every datapath select, enable and status output.
interface rv_multicycle_ctrl_if #(
    parameter int CNT_W = 32
) ();
    logic [6:0]       opcode;
    logic             branch_taken;
    logic             mem_ready;
    logic             mem_req;
    logic             mem_we;
    logic             adr_src;
    logic             ir_write;
    logic             pc_write;
    logic             reg_write;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [1:0]       result_src;
    logic             illegal;
    logic [3:0]       state;
    logic [CNT_W-1:0] instret;

    modport master (
        input  opcode, branch_taken, mem_ready,
        output mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, alu_op, result_src,
               illegal, state, instret
    );

    modport slave (
        output opcode, branch_taken, mem_ready,
        input  mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
               alu_src_a, alu_src_b, alu_op, result_src,
               illegal, state, instret
    );
endinterface

// File: rtl/rv_multicycle_ctrl.sv
// Main sequencing FSM of the multi-cycle RV32 core. Steps the shared ALU,
// the unified memory port and the register file through fetch, decode,
// execute, memory and writeback; counts retired instructions and parks in
// TRAP on an illegal opcode or when memory fails to answer in time.
module rv_multicycle_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rv_multicycle_ctrl_if.master  bus
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        EXEC_R   = 4'd6,
        EXEC_I   = 4'd7,
        ALU_WB   = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        JALR     = 4'd11,
        EXEC_U   = 4'd12,
        LINK     = 4'd13,
        TRAP     = 4'd14
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_AMO   = 7'b0101111;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    // Wait counter only has to reach MEM_TIMEOUT, so size it to that.
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(MEM_TIMEOUT);
    localparam bit TIMEOUT_EN = (MEM_TIMEOUT != 0);

    state_t             state_q, state_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [CNT_W-1:0]   instret_q, instret_d;
    logic               retire;
    logic               waiting;
    logic               timeout;

    // A memory-facing state is stalled when the request is not answered; the
    // timeout fires on the stall cycle where the count has already reached
    // the limit, so a late mem_ready in that very cycle still wins.
    always_comb begin
        waiting = ((state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR))
                  && !bus.mem_ready;
        timeout = TIMEOUT_EN && waiting && (wait_q == TIMEOUT_VAL);
    end

    // Next-state selection and retirement detection.
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        unique case (state_q)
            FETCH: begin
                if (bus.mem_ready)  state_d = DECODE;
                else if (timeout)   state_d = TRAP;
            end
            DECODE: begin
                case (bus.opcode)
                    OP_LOAD, OP_STORE: state_d = MEM_ADDR;
                    OP_R, OP_AMO:      state_d = EXEC_R;
                    OP_I:              state_d = EXEC_I;
                    OP_BR:             state_d = BRANCH;
                    OP_JAL:            state_d = JAL;
                    OP_JALR:           state_d = JALR;
                    OP_LUI, OP_AUIPC:  state_d = EXEC_U;
                    default:           state_d = TRAP;
                endcase
            end
            MEM_ADDR: state_d = bus.opcode[5] ? MEM_WR : MEM_RD;
            MEM_RD: begin
                if (bus.mem_ready)  state_d = MEM_WB;
                else if (timeout)   state_d = TRAP;
            end
            MEM_WB: begin
                state_d = FETCH;
                retire  = 1'b1;
            end
            MEM_WR: begin
                if (bus.mem_ready) begin
                    state_d = FETCH;
                    retire  = 1'b1;
                end else if (timeout) begin
                    state_d = TRAP;
                end
            end
            EXEC_R, EXEC_I, EXEC_U: state_d = ALU_WB;
            ALU_WB, BRANCH: begin
                state_d = FETCH;
                retire  = 1'b1;
            end
            JAL:     state_d = ALU_WB;
            JALR:    state_d = LINK;
            LINK:    state_d = ALU_WB;
            TRAP:    state_d = TRAP;
            default: state_d = TRAP;
        endcase
    end

    // Wait counter restarts on every state change and counts stall cycles.
    always_comb begin
        wait_d = wait_q;
        if (state_d != state_q) begin
            wait_d = '0;
        end else if (TIMEOUT_EN && waiting) begin
            wait_d = wait_q + WAIT_W'(1);
        end
        instret_d = retire ? (instret_q + CNT_W'(1)) : instret_q;
    end

    // State, wait counter and retired-instruction counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= FETCH;
            wait_q    <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
        end
    end

    // Datapath control decode; everything not named in a state stays 0.
    always_comb begin
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.adr_src    = 1'b0;
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.reg_write  = 1'b0;
        bus.alu_src_a  = 2'b00;
        bus.alu_src_b  = 2'b00;
        bus.alu_op     = 2'b00;
        bus.result_src = 2'b00;
        bus.illegal    = 1'b0;
        unique case (state_q)
            FETCH: begin
                bus.mem_req    = 1'b1;
                bus.alu_src_b  = 2'b10;
                bus.result_src = 2'b10;
                bus.ir_write   = bus.mem_ready;
                bus.pc_write   = bus.mem_ready;
            end
            DECODE: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b01;
            end
            MEM_ADDR: begin
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = 2'b01;
            end
            MEM_RD: begin
                bus.mem_req = 1'b1;
                bus.adr_src = 1'b1;
            end
            MEM_WB: begin
                bus.reg_write  = 1'b1;
                bus.result_src = 2'b01;
            end
            MEM_WR: begin
                bus.mem_req = 1'b1;
                bus.mem_we  = 1'b1;
                bus.adr_src = 1'b1;
            end
            EXEC_R: begin
                bus.alu_src_a = 2'b10;
                bus.alu_op    = 2'b10;
            end
            EXEC_I: begin
                bus.alu_src_a = 2'b10;
                bus.alu_src_b = 2'b01;
                bus.alu_op    = 2'b10;
            end
            EXEC_U: begin
                bus.alu_src_a = bus.opcode[5] ? 2'b11 : 2'b01;
                bus.alu_src_b = 2'b01;
            end
            ALU_WB: bus.reg_write = 1'b1;
            BRANCH: begin
                bus.alu_src_a = 2'b10;
                bus.alu_op    = 2'b01;
                bus.pc_write  = bus.branch_taken;
            end
            JAL: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b10;
                bus.pc_write  = 1'b1;
            end
            JALR: begin
                bus.alu_src_a  = 2'b10;
                bus.alu_src_b  = 2'b01;
                bus.result_src = 2'b10;
                bus.pc_write   = 1'b1;
            end
            LINK: begin
                bus.alu_src_a = 2'b01;
                bus.alu_src_b = 2'b10;
            end
            TRAP:    bus.illegal = 1'b1;
            default: bus.illegal = 1'b1;
        endcase
    end

    assign bus.state   = state_q;
    assign bus.instret = instret_q;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Self-checking bench for rv_multicycle_ctrl. Instructions are described at
// the instruction level (opcode, branch outcome, fetch and memory latency);
// the expected per-cycle state walk, control outputs and retire count are
// generated from that description and compared every cycle.
module tb_rv_multicycle_ctrl;

    localparam int CNT_W = 4;
    localparam int TMO   = 4;

    localparam int S_FETCH = 0, S_DECODE = 1, S_MEM_ADDR = 2, S_MEM_RD = 3,
                   S_MEM_WB = 4, S_MEM_WR = 5, S_EXEC_R = 6, S_EXEC_I = 7,
                   S_ALU_WB = 8, S_BRANCH = 9, S_JAL = 10, S_JALR = 11,
                   S_EXEC_U = 12, S_LINK = 13, S_TRAP = 14;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_AMO   = 7'b0101111;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_FENCE = 7'b0001111;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int passCount    = 0;
    int checkCount   = 0;
    int modelInstret = 0;

    logic [6:0] legalOps [10];
    logic [6:0] illegalOps [4];

    rv_multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();

    rv_multicycle_ctrl #(
        .CNT_W       (CNT_W),
        .MEM_TIMEOUT (TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected control word for one cycle, straight from the state table.
    function automatic logic [14:0] expCtrl(int st, logic [6:0] opc, logic rdy, logic bt);
        logic req, we, adr, irw, pcw, rw, ill;
        logic [1:0] a, b, op, rs;
        req = 0; we = 0; adr = 0; irw = 0; pcw = 0; rw = 0; ill = 0;
        a = 0; b = 0; op = 0; rs = 0;
        case (st)
            S_FETCH:    begin req = 1; b = 2; rs = 2; irw = rdy; pcw = rdy; end
            S_DECODE:   begin a = 1; b = 1; end
            S_MEM_ADDR: begin a = 2; b = 1; end
            S_MEM_RD:   begin req = 1; adr = 1; end
            S_MEM_WB:   begin rw = 1; rs = 1; end
            S_MEM_WR:   begin req = 1; we = 1; adr = 1; end
            S_EXEC_R:   begin a = 2; op = 2; end
            S_EXEC_I:   begin a = 2; b = 1; op = 2; end
            S_EXEC_U:   begin a = opc[5] ? 2'd3 : 2'd1; b = 1; end
            S_ALU_WB:   begin rw = 1; end
            S_BRANCH:   begin a = 2; op = 1; pcw = bt; end
            S_JAL:      begin a = 1; b = 2; pcw = 1; end
            S_JALR:     begin a = 2; b = 1; rs = 2; pcw = 1; end
            S_LINK:     begin a = 1; b = 2; end
            S_TRAP:     begin ill = 1; end
            default:    begin ill = 1; end
        endcase
        return {req, we, adr, irw, pcw, rw, a, b, op, rs, ill};
    endfunction

    task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock cycle: drive inputs just after the edge, check before the next.
    task automatic applyStimulus(int st, logic rdy, logic [6:0] opc, logic bt);
        logic [14:0] obsCtrl;
        bus.mem_ready    = rdy;
        bus.opcode       = opc;
        bus.branch_taken = bt;
        #2;
        obsCtrl = {bus.mem_req, bus.mem_we, bus.adr_src, bus.ir_write, bus.pc_write,
                   bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                   bus.result_src, bus.illegal};
        checkOutput($sformatf("state[exp %0d]", st), 32'(bus.state), 32'(st));
        checkOutput($sformatf("ctrl[st %0d]", st), 32'(obsCtrl), 32'(expCtrl(st, opc, rdy, bt)));
        checkOutput($sformatf("instret[st %0d]", st), 32'(bus.instret), 32'(modelInstret));
        @(posedge clk);
        #1;
    endtask

    task automatic retireModel();
        modelInstret = (modelInstret + 1) % (1 << CNT_W);
    endtask

    // Stall lat cycles then answer; a stall that reaches the limit traps.
    task automatic memWait(int st, int lat, logic [6:0] opc, output bit ok);
        ok = 1'b0;
        for (int k = 0; k <= TMO; k++) begin
            applyStimulus(st, logic'(k >= lat), opc, rnd());
            if (k >= lat) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    // Async reset asserted mid-cycle must clear state and counters at once.
    task automatic applyReset();
        rst_n = 1'b0;
        #1;
        modelInstret = 0;
        checkOutput("reset state", 32'(bus.state), 32'(S_FETCH));
        checkOutput("reset illegal", 32'(bus.illegal), 32'd0);
        checkOutput("reset instret", 32'(bus.instret), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic trapAndReset(int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(S_TRAP, rnd(), 7'($urandom), rnd());
        end
        applyReset();
    endtask

    // Whole instruction from FETCH to retirement or trap.
    task automatic runInstr(logic [6:0] opc, logic bt, int fLat, int mLat, int trapLen);
        bit ok;
        memWait(S_FETCH, fLat, 7'($urandom), ok);
        if (!ok) begin
            trapAndReset(trapLen);
            return;
        end
        applyStimulus(S_DECODE, rnd(), opc, rnd());
        ok = 1'b1;
        case (opc)
            OP_LOAD: begin
                applyStimulus(S_MEM_ADDR, rnd(), opc, rnd());
                memWait(S_MEM_RD, mLat, opc, ok);
                if (ok) begin
                    applyStimulus(S_MEM_WB, rnd(), opc, rnd());
                    retireModel();
                end
            end
            OP_STORE: begin
                applyStimulus(S_MEM_ADDR, rnd(), opc, rnd());
                memWait(S_MEM_WR, mLat, opc, ok);
                if (ok) retireModel();
            end
            OP_R, OP_AMO, OP_I, OP_LUI, OP_AUIPC: begin
                if (opc == OP_I)                         applyStimulus(S_EXEC_I, rnd(), opc, rnd());
                else if (opc == OP_LUI || opc == OP_AUIPC) applyStimulus(S_EXEC_U, rnd(), opc, rnd());
                else                                     applyStimulus(S_EXEC_R, rnd(), opc, rnd());
                applyStimulus(S_ALU_WB, rnd(), opc, rnd());
                retireModel();
            end
            OP_BR: begin
                applyStimulus(S_BRANCH, rnd(), opc, bt);
                retireModel();
            end
            OP_JAL: begin
                applyStimulus(S_JAL, rnd(), opc, rnd());
                applyStimulus(S_ALU_WB, rnd(), opc, rnd());
                retireModel();
            end
            OP_JALR: begin
                applyStimulus(S_JALR, rnd(), opc, rnd());
                applyStimulus(S_LINK, rnd(), opc, rnd());
                applyStimulus(S_ALU_WB, rnd(), opc, rnd());
                retireModel();
            end
            default: ok = 1'b0;
        endcase
        if (!ok) trapAndReset(trapLen);
    endtask

    // Directed scenarios first, then a randomized instruction stream.
    initial begin
        bit ok;
        legalOps   = '{OP_LOAD, OP_STORE, OP_R, OP_AMO, OP_I, OP_BR,
                       OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
        illegalOps = '{OP_FENCE, 7'b1110011, 7'b0000000, 7'b1111111};
        bus.mem_ready    = 1'b0;
        bus.opcode       = 7'b0;
        bus.branch_taken = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("por state", 32'(bus.state), 32'(S_FETCH));
        checkOutput("por illegal", 32'(bus.illegal), 32'd0);
        checkOutput("por instret", 32'(bus.instret), 32'd0);
        rst_n = 1'b1;

        $display("[TB] directed: R-type, load, branches, JALR");
        runInstr(OP_R, 1'b0, 0, 0, 1);
        runInstr(OP_LOAD, 1'b0, 0, 3, 1);
        runInstr(OP_BR, 1'b1, 1, 0, 1);
        runInstr(OP_BR, 1'b0, 0, 0, 1);
        runInstr(OP_JALR, 1'b0, 2, 0, 1);
        runInstr(OP_STORE, 1'b0, 4, 4, 1);
        runInstr(OP_LUI, 1'b0, 0, 0, 1);
        runInstr(OP_AUIPC, 1'b0, 0, 0, 1);

        $display("[TB] directed: illegal opcode trap");
        runInstr(OP_FENCE, 1'b0, 0, 0, 100);

        $display("[TB] directed: fetch timeout and last-cycle ready");
        runInstr(OP_R, 1'b0, 0, 0, 1);
        runInstr(OP_R, 1'b0, 5, 0, 3);
        runInstr(OP_R, 1'b0, 4, 0, 1);
        runInstr(OP_LOAD, 1'b0, 0, 5, 2);

        $display("[TB] directed: reset in the middle of a load");
        runInstr(OP_JAL, 1'b0, 0, 0, 1);
        memWait(S_FETCH, 0, OP_LOAD, ok);
        applyStimulus(S_DECODE, 1'b0, OP_LOAD, 1'b0);
        applyStimulus(S_MEM_ADDR, 1'b0, OP_LOAD, 1'b0);
        applyStimulus(S_MEM_RD, 1'b0, OP_LOAD, 1'b0);
        applyReset();

        $display("[TB] random instruction stream");
        for (int n = 0; n < 300; n++) begin
            logic [6:0] opc;
            int fLat, mLat;
            opc  = ($urandom_range(0, 24) == 0) ? illegalOps[$urandom_range(0, 3)]
                                                : legalOps[$urandom_range(0, 9)];
            fLat = ($urandom_range(0, 29) == 0) ? TMO + 1 : int'($urandom_range(0, TMO));
            mLat = ($urandom_range(0, 29) == 0) ? TMO + 1 : int'($urandom_range(0, TMO));
            runInstr(opc, rnd(), fLat, mLat, int'($urandom_range(1, 4)));
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
